tone_scheduler: RTL and testbench

Sequences and arbitrates everything that drives the 4-bit voice code of the audio output path. It takes player key tones, game prompt tones (`key_random`) and end-of-game jingles, and plays each one as a timed note followed by a silent gap. It applies a fixed priority and a game-over mute. Its registered `voice` output feeds the DAC serializer in place of a free-running key-to-voice decode.

---
 rtl/tone_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_tone_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_scheduler.sv
// tone_scheduler
//   Arbitrates and sequences the 4-bit voice code feeding the DAC serializer.
//   Player key tones, game prompt tones and end-of-game jingles are each played
//   as a timed note followed by a silent gap. Priority is jingle > game-over
//   mute > key > prompt; a key may cut short a prompt, a prompt never preempts.
//
// Parameters
//   NOTE_TICKS   note length in clk cycles (1..2^26-1)
//   GAP_TICKS    silent gap after each note in clk cycles (1..2^26-1)
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   key_valid/key          player key pulse and note code
//   prompt_valid/key_random game prompt pulse and note code
//   jingle_start/jingle_sel start end-of-game jingle (1 = win, 0 = lose)
//   finish         game-over level; mutes key and prompt tones
//   voice          registered note code, 0 = silence
//   busy           playing a note or gap (not IDLE, not MUTE)
//   key_ack        one-cycle pulse on the first cycle of a key note
//   prompt_ack     one-cycle pulse on the first cycle of a prompt note
//   jingle_done    one-cycle pulse after the final gap of a jingle
module tone_scheduler #(
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       prompt_valid,
    input  logic [3:0] key_random,
    input  logic       jingle_start,
    input  logic       jingle_sel,
    input  logic       finish,
    output logic [3:0] voice,
    output logic       busy,
    output logic       key_ack,
    output logic       prompt_ack,
    output logic       jingle_done
);

    typedef enum logic [2:0] {IDLE, NOTE, GAP, JNOTE, JGAP, MUTE} state_t;

    localparam logic [25:0] NOTE_LOAD = 26'(NOTE_TICKS - 1);
    localparam logic [25:0] GAP_LOAD  = 26'(GAP_TICKS - 1);

    // win = 1,3,5,8,5,8,10,12 ; lose is a descending scale 8..1
    function automatic logic [3:0] jingle_note(input logic sel, input logic [2:0] idx);
        logic [3:0] n;
        n = 4'd8 - {1'b0, idx};
        if (sel) begin
            case (idx)
                3'd0:    n = 4'd1;
                3'd1:    n = 4'd3;
                3'd2:    n = 4'd5;
                3'd3:    n = 4'd8;
                3'd4:    n = 4'd5;
                3'd5:    n = 4'd8;
                3'd6:    n = 4'd10;
                default: n = 4'd12;
            endcase
        end
        return n;
    endfunction

    state_t      state, state_n;
    logic [25:0] tick, tick_n;
    logic [2:0]  jidx, jidx_n;
    logic        jsel, jsel_n;
    logic        cur_prompt, cur_prompt_n;   // note/gap in progress belongs to a prompt
    logic        kpend, kpend_n, ppend, ppend_n;
    logic [3:0]  kcode, kcode_n, pcode, pcode_n;
    logic [3:0]  voice_n;
    logic        key_ack_n, prompt_ack_n, jdone_n;
    logic        start_key, start_prompt, go_mute;

    always_comb begin
        state_n      = state;
        tick_n       = tick;
        jidx_n       = jidx;
        jsel_n       = jsel;
        cur_prompt_n = cur_prompt;
        // Unconsumed pulses become pending; a newer one replaces the stored code.
        kpend_n      = kpend | key_valid;
        kcode_n      = key_valid ? key : kcode;
        ppend_n      = ppend | prompt_valid;
        pcode_n      = prompt_valid ? key_random : pcode;
        voice_n      = voice;
        key_ack_n    = 1'b0;
        prompt_ack_n = 1'b0;
        jdone_n      = 1'b0;
        start_key    = 1'b0;
        start_prompt = 1'b0;
        go_mute      = 1'b0;

        case (state)
            IDLE: begin
                if (finish)                      go_mute = 1'b1;
                else if (key_valid || kpend)     start_key = 1'b1;
                else if (prompt_valid || ppend)  start_prompt = 1'b1;
            end
            NOTE, GAP: begin
                if (finish) begin
                    go_mute = 1'b1;
                end else if (cur_prompt && key_valid) begin
                    // key aborts the prompt; the prompt is not replayed
                    start_key = 1'b1;
                end else if (tick == 26'd0) begin
                    voice_n = 4'd0;
                    if (state == NOTE) begin
                        state_n = GAP;
                        tick_n  = GAP_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    tick_n = tick - 26'd1;
                end
            end
            JNOTE: begin
                if (tick == 26'd0) begin
                    state_n = JGAP;
                    tick_n  = GAP_LOAD;
                    voice_n = 4'd0;
                end else begin
                    tick_n = tick - 26'd1;
                end
            end
            JGAP: begin
                if (tick == 26'd0) begin
                    if (jidx == 3'd7) begin
                        jdone_n = 1'b1;
                        if (finish) go_mute = 1'b1;
                        else        state_n = IDLE;
                    end else begin
                        jidx_n  = jidx + 3'd1;
                        state_n = JNOTE;
                        tick_n  = NOTE_LOAD;
                        voice_n = jingle_note(jsel, jidx + 3'd1);
                    end
                end else begin
                    tick_n = tick - 26'd1;
                end
            end
            MUTE: begin
                kpend_n = 1'b0;
                ppend_n = 1'b0;
                if (!finish) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (start_key) begin
            state_n      = NOTE;
            tick_n       = NOTE_LOAD;
            voice_n      = key_valid ? key : kcode;
            key_ack_n    = 1'b1;
            kpend_n      = 1'b0;
            cur_prompt_n = 1'b0;
        end
        if (start_prompt) begin
            state_n      = NOTE;
            tick_n       = NOTE_LOAD;
            voice_n      = prompt_valid ? key_random : pcode;
            prompt_ack_n = 1'b1;
            ppend_n      = 1'b0;
            cur_prompt_n = 1'b1;
        end
        if (go_mute) begin
            state_n = MUTE;
            voice_n = 4'd0;
            kpend_n = 1'b0;
            ppend_n = 1'b0;
        end
        // Jingle start overrides everything, in every state.
        if (jingle_start) begin
            state_n      = JNOTE;
            tick_n       = NOTE_LOAD;
            jidx_n       = 3'd0;
            jsel_n       = jingle_sel;
            voice_n      = jingle_note(jingle_sel, 3'd0);
            kpend_n      = 1'b0;
            ppend_n      = 1'b0;
            key_ack_n    = 1'b0;
            prompt_ack_n = 1'b0;
            jdone_n      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick        <= 26'd0;
            jidx        <= 3'd0;
            jsel        <= 1'b0;
            cur_prompt  <= 1'b0;
            kpend       <= 1'b0;
            kcode       <= 4'd0;
            ppend       <= 1'b0;
            pcode       <= 4'd0;
            voice       <= 4'd0;
            key_ack     <= 1'b0;
            prompt_ack  <= 1'b0;
            jingle_done <= 1'b0;
        end else begin
            state       <= state_n;
            tick        <= tick_n;
            jidx        <= jidx_n;
            jsel        <= jsel_n;
            cur_prompt  <= cur_prompt_n;
            kpend       <= kpend_n;
            kcode       <= kcode_n;
            ppend       <= ppend_n;
            pcode       <= pcode_n;
            voice       <= voice_n;
            key_ack     <= key_ack_n;
            prompt_ack  <= prompt_ack_n;
            jingle_done <= jdone_n;
        end
    end

    assign busy = (state == NOTE) || (state == GAP) || (state == JNOTE) || (state == JGAP);

endmodule

// File: tb/tb_tone_scheduler.sv
// Testbench for tone_scheduler: directed test-plan scenarios followed by random
// traffic. Expected outputs come from an activity/offset based reference model
// and are queued; a negedge monitor pops and compares every cycle.
module tb_tone_scheduler;

    localparam int NT       = 4;
    localparam int GT       = 2;
    localparam int TONE_LEN = NT + GT;
    localparam int JING_LEN = 8 * TONE_LEN;

    localparam int K_IDLE = 0, K_KEY = 1, K_PROMPT = 2, K_JING = 3, K_MUTE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0, prompt_valid = 1'b0, jingle_start = 1'b0;
    logic       jingle_sel = 1'b0, finish = 1'b0;
    logic [3:0] key = 4'd0, key_random = 4'd0;
    logic [3:0] voice;
    logic       busy, key_ack, prompt_ack, jingle_done;

    tone_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key(key),
        .prompt_valid(prompt_valid), .key_random(key_random),
        .jingle_start(jingle_start), .jingle_sel(jingle_sel),
        .finish(finish),
        .voice(voice), .busy(busy), .key_ack(key_ack),
        .prompt_ack(prompt_ack), .jingle_done(jingle_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] voice;
        logic       busy;
        logic       kack;
        logic       pack;
        logic       jdone;
    } exp_t;

    exp_t expq[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   fin_lvl = 1'b0;

    logic [3:0] win_rom  [8] = '{4'd1, 4'd3, 4'd5, 4'd8, 4'd5, 4'd8, 4'd10, 4'd12};
    logic [3:0] lose_rom [8] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    // Reference model: what is playing, when it started, and what is waiting.
    int         kind, st, cur;
    bit         kp, pp, m_jsel, m_kack, m_pack, m_done;
    logic [3:0] kc, pc, tc;

    task automatic model_reset();
        kind = K_IDLE; st = 0; cur = 0;
        kp = 1'b0; pp = 1'b0; kc = 4'd0; pc = 4'd0; tc = 4'd0; m_jsel = 1'b0;
    endtask

    task automatic push_zero();
        exp_t z;
        z = '0;
        expq.push_back(z);
    endtask

    // Advance the model by one cycle given this cycle's inputs and queue the
    // outputs the DUT must show in the following cycle.
    task automatic model_step(input bit kv, input logic [3:0] k, input bit pv,
                              input logic [3:0] kr, input bit js, input bit jsl,
                              input bit fin);
        int   o;
        exp_t e;
        o = cur - st;
        m_kack = 1'b0; m_pack = 1'b0; m_done = 1'b0;
        if (js) begin
            kind = K_JING; st = cur + 1; m_jsel = jsl; kp = 1'b0; pp = 1'b0;
        end else begin
            case (kind)
                K_IDLE: begin
                    if (fin) begin
                        kind = K_MUTE; kp = 1'b0; pp = 1'b0;
                    end else if (kv || kp) begin
                        kind = K_KEY; st = cur + 1; tc = kv ? k : kc; kp = 1'b0; m_kack = 1'b1;
                        if (pv) begin pp = 1'b1; pc = kr; end
                    end else if (pv || pp) begin
                        kind = K_PROMPT; st = cur + 1; tc = pv ? kr : pc; pp = 1'b0; m_pack = 1'b1;
                    end
                end
                K_KEY, K_PROMPT: begin
                    if (fin) begin
                        kind = K_MUTE; kp = 1'b0; pp = 1'b0;
                    end else if (kind == K_PROMPT && kv) begin
                        kind = K_KEY; st = cur + 1; tc = k; m_kack = 1'b1;
                        if (pv) begin pp = 1'b1; pc = kr; end
                    end else begin
                        if (kv) begin kp = 1'b1; kc = k; end
                        if (pv) begin pp = 1'b1; pc = kr; end
                        if (o == TONE_LEN - 1) kind = K_IDLE;
                    end
                end
                K_JING: begin
                    if (kv) begin kp = 1'b1; kc = k; end
                    if (pv) begin pp = 1'b1; pc = kr; end
                    if (o == JING_LEN - 1) begin
                        m_done = 1'b1;
                        if (fin) begin kind = K_MUTE; kp = 1'b0; pp = 1'b0; end
                        else kind = K_IDLE;
                    end
                end
                default: begin
                    kp = 1'b0; pp = 1'b0;
                    if (!fin) kind = K_IDLE;
                end
            endcase
        end
        cur = cur + 1;
        o = cur - st;
        e = '0;
        if (kind == K_KEY || kind == K_PROMPT)
            e.voice = (o < NT) ? tc : 4'd0;
        else if (kind == K_JING)
            e.voice = ((o % TONE_LEN) < NT) ? (m_jsel ? win_rom[o / TONE_LEN] : lose_rom[o / TONE_LEN]) : 4'd0;
        e.busy  = (kind == K_KEY || kind == K_PROMPT || kind == K_JING);
        e.kack  = m_kack;
        e.pack  = m_pack;
        e.jdone = m_done;
        expq.push_back(e);
    endtask

    // Drive one cycle of inputs (called at posedge+1), then advance a cycle.
    task automatic step(input bit kv, input logic [3:0] k, input bit pv,
                        input logic [3:0] kr, input bit js, input bit jsl);
        key_valid = kv; key = k; prompt_valid = pv; key_random = kr;
        jingle_start = js; jingle_sel = jsl; finish = fin_lvl;
        model_step(kv, k, pv, kr, js, jsl, fin_lvl);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (expq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_underflow t=%0t no expected entry", $time);
            end else begin
                e_mon = expq.pop_front();
                n_cmp++;
                if ({voice, busy, key_ack, prompt_ack, jingle_done} !== e_mon) begin
                    n_bad++;
                    $display("FAIL sb t=%0t got voice=%0d busy=%0b kack=%0b pack=%0b jdone=%0b want voice=%0d busy=%0b kack=%0b pack=%0b jdone=%0b",
                             $time, voice, busy, key_ack, prompt_ack, jingle_done,
                             e_mon.voice, e_mon.busy, e_mon.kack, e_mon.pack, e_mon.jdone);
                end
            end
        end
    end

    initial begin
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        push_zero();            // reset state while rst is held
        mon_en = 1'b1;
        @(posedge clk); #1;
        push_zero();
        rst = 1'b0;

        // single key
        step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0); idle(8);
        // key and prompt in the same cycle
        step(1'b1, 4'd3, 1'b1, 4'd9, 1'b0, 1'b0); idle(16);
        // key preempts a playing prompt
        step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0); idle(2);
        step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0); idle(10);
        // key preempts a prompt in its gap; rest code 0 still acknowledged
        step(1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0); idle(4);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); idle(8);
        // win jingle with finish held: ends in MUTE
        fin_lvl = 1'b1;
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1); idle(52);
        // mute: key pulses ignored, nothing stale after finish drops
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'(i + 4), 1'b0, 4'd0, 1'b0, 1'b0); idle(1);
        end
        fin_lvl = 1'b0;
        idle(10);
        // lose jingle with key/prompt captured during it, restart mid-jingle
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0); idle(10);
        step(1'b1, 4'd6, 1'b1, 4'd11, 1'b0, 1'b0); idle(5);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0); idle(10);
        step(1'b1, 4'd13, 1'b1, 4'd14, 1'b0, 1'b0); idle(60);
        // all three requests together: jingle wins, key/prompt dropped
        step(1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1); idle(55);
        // finish rising during a key note
        step(1'b1, 4'd9, 1'b1, 4'd3, 1'b0, 1'b0); idle(1);
        fin_lvl = 1'b1; idle(3);
        fin_lvl = 1'b0; idle(4);

        // reset mid-note
        step(1'b1, 4'd10, 1'b1, 4'd1, 1'b0, 1'b0); idle(1);
        expq.delete();
        push_zero();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        push_zero();
        rst = 1'b0;
        model_reset();
        idle(12);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) fin_lvl = ~fin_lvl;
            step($urandom_range(0, 7) == 0, 4'($urandom), $urandom_range(0, 5) == 0,
                 4'($urandom), $urandom_range(0, 79) == 0, 1'($urandom));
        end
        fin_lvl = 1'b0;
        idle(60);

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
